// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential advance, stall, jump/branch redirect,
// exception entry/return with EPC capture and misaligned-target trapping.
module pc_gen #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
    parameter int unsigned      INC       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] bad_addr,
    output logic             in_kernel
);

    typedef enum logic {
        USER   = 1'b0,
        KERNEL = 1'b1
    } mode_e;

    mode_e            state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] bad_addr_q, bad_addr_d;
    logic [WIDTH-1:0] target;
    logic             redirect;

    assign pc_plus   = pc_q + WIDTH'(INC);
    assign redirect  = jump | branch_taken;
    assign target    = jump ? jump_target : branch_target;

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        bad_addr_d = bad_addr_q;
        state_d    = state_q;
        if (exc_req) begin
            pc_d = EXC_VEC;
            // Nested entry keeps the original return address.
            if (state_q == USER) begin
                epc_d   = pc_q;
                state_d = KERNEL;
            end
        end else if (stall) begin
            // hold everything; dropped redirects are re-presented by the pipeline
        end else if (eret && state_q == KERNEL) begin
            pc_d    = epc_q;
            state_d = USER;
        end else if (redirect) begin
            if (target[1:0] != 2'b00) begin
                pc_d       = EXC_VEC;
                bad_addr_d = target;
                if (state_q == USER) begin
                    epc_d   = pc_q;
                    state_d = KERNEL;
                end
            end else begin
                pc_d = target;
            end
        end else begin
            pc_d = pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            bad_addr_q <= '0;
            state_q    <= USER;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            bad_addr_q <= bad_addr_d;
            state_q    <= state_d;
        end
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign bad_addr  = bad_addr_q;
    assign in_kernel = (state_q == KERNEL);

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the plain resettable PC flop.
- Sits at the front of the fetch stage and drives the instruction-memory address.
- Adds stall, jump and branch redirect, exception entry with EPC capture, exception return, and misaligned-target trapping.
- Two-state mode machine (USER/KERNEL) gives exception-level semantics.

Parameters:
- WIDTH, 32, PC/address width in bits (>= 8).
- RESET_VEC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC (fetch stalled).
- jump  in  1  unconditional redirect request.
- jump_target  in  WIDTH  jump destination.
- branch_taken  in  1  taken-branch redirect request.
- branch_target  in  WIDTH  branch destination.
- exc_req  in  1  exception request from pipeline.
- eret  in  1  return-from-exception request.
- pc  out  WIDTH  current fetch address (registered).
- pc_plus  out  WIDTH  pc + INC (combinational from pc).
- epc  out  WIDTH  exception PC (registered).
- bad_addr  out  WIDTH  last misaligned target (registered).
- in_kernel  out  1  1 when state == KERNEL.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high, sampled on the rising edge of clk; it has no asynchronous path.
- Reset (sampled high at a rising edge): pc = RESET_VEC, epc = 0, bad_addr = 0, state = USER, in_kernel = 0. Reset overrides every other input. Reset mid-exception returns to USER with epc cleared.
- State encoding: USER (0), KERNEL (1). in_kernel is the state register itself, with no extra latency.
- Next-PC priority, evaluated each rising edge when reset is low, highest first:
  1. exc_req: pc <= EXC_VEC. In USER: epc <= pc, state <= KERNEL. In KERNEL (nested): epc is unchanged, state stays KERNEL. exc_req overrides stall.
  2. stall: pc, epc, bad_addr and state all hold. A concurrent eret, jump or branch is dropped; the pipeline re-presents it.
  3. eret: in KERNEL, pc <= epc and state <= USER. In USER, eret is ignored and evaluation falls through to items 4-6.
  4. jump: target = jump_target.
  5. branch_taken: target = branch_target.
  6. Otherwise pc <= pc + INC, truncated modulo 2^WIDTH (wraps all-ones region to 0, no flag).
- Redirect alignment check (items 4 and 5): if target[1:0] != 0, treat the redirect as an exception:
  - pc <= EXC_VEC and bad_addr <= target.
  - In USER: epc <= pc and state <= KERNEL. In KERNEL: epc is unchanged.
  - If target is aligned: pc <= target.
- jump and branch_taken both high: jump wins, branch_target is ignored.
- Latency:
  - Every redirect takes effect on pc one cycle after being sampled.
  - pc_plus follows pc combinationally (zero cycles).
  - epc and bad_addr update in the same edge as the pc change.
- epc and bad_addr change only in the cases listed above.

Test Plan:
- Reset then free-run: hold reset 2 cycles, release -> pc 0x3000, 0x3004, 0x3008 on successive edges; pc_plus = pc + 4; in_kernel = 0.
- Stall and redirect: at pc = 0x3008 assert stall + jump (target 0x3100) for 2 cycles -> pc holds 0x3008. Release stall with jump held -> pc = 0x3100 next cycle. jump + branch_taken (0x3200) together -> pc = jump target.
- Exception entry/return: at pc = 0x3010 pulse exc_req -> pc = 0x4180, epc = 0x3010, in_kernel = 1. Nested exc_req at pc 0x4184 -> pc = 0x4180, epc still 0x3010. eret -> pc = 0x3010, in_kernel = 0.
- Exception beats stall; eret in USER: exc_req + stall at pc = 0x3020 -> pc = 0x4180, epc = 0x3020. In USER, eret alone at pc = 0x3000 -> pc = 0x3004, no state change.
- Misaligned target: branch_taken with branch_target = 0x3102 at pc = 0x3040 -> pc = 0x4180, bad_addr = 0x3102, epc = 0x3040, in_kernel = 1.
- Wrap and mid-op reset: with WIDTH = 16 and pc = 0xFFFC -> next pc = 0x0000. In KERNEL with epc = 0x3010, assert reset -> pc = 0x3000, epc = 0, in_kernel = 0 on the same edge.
